mat_vec_mul_fx: RTL and testbench

//   Parametrised signed fixed-point DIMxDIM matrix by DIM-vector multiplier (y = A*x) for the render

---
 rtl/mat_vec_mul_fx.sv | 118 +++++++++++
 tb/tb_mat_vec_mul_fx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_vec_mul_fx.sv
// Signed fixed-point DIMxDIM matrix by DIM-vector multiplier (y = A*x).
// One column is accumulated per cycle; results are rounded and saturated to DATAWIDTH.
module mat_vec_mul_fx #(
  parameter int DATAWIDTH = 32,
  parameter int FRACBITS  = 16,
  parameter int DIM       = 4
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [DIM-1:0][DIM-1:0][DATAWIDTH-1:0] A,
  input  logic [DIM-1:0][DATAWIDTH-1:0]          x,
  input  logic                                  i_dv,
  output logic                                  o_ready,
  output logic [DIM-1:0][DATAWIDTH-1:0]          y,
  output logic                                  o_dv,
  input  logic                                  i_ready,
  output logic                                  o_overflow
);

  localparam int ACCWIDTH = 2*DATAWIDTH + $clog2(DIM);
  localparam int IDXW     = $clog2(DIM);
  localparam int PW       = 2*DATAWIDTH;
  localparam int RW       = ACCWIDTH + 1;
  localparam int RSH      = (FRACBITS > 0) ? FRACBITS - 1 : 0;

  localparam logic signed [RW-1:0] RND_C   = (FRACBITS > 0) ? (RW'(1) << RSH) : '0;
  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-DATAWIDTH+1){1'b0}}, {(DATAWIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-DATAWIDTH+1){1'b1}}, {(DATAWIDTH-1){1'b0}}};
  localparam logic [IDXW-1:0]      LAST    = IDXW'(DIM-1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PROCESSING = 2'd1,
    DONE       = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   accept;

  logic [DIM-1:0][DIM-1:0][DATAWIDTH-1:0] a_r;
  logic [DIM-1:0][DATAWIDTH-1:0]          x_r;
  logic [DIM-1:0][DATAWIDTH-1:0]          y_nxt;
  logic [IDXW-1:0]                        idx;
  logic [DIM-1:0]                         clamp;

  logic signed [ACCWIDTH-1:0] acc     [DIM];
  logic signed [ACCWIDTH-1:0] acc_sum [DIM];
  logic signed [PW-1:0]       prod    [DIM];
  logic signed [RW-1:0]       rnd     [DIM];
  logic signed [RW-1:0]       shv     [DIM];

  assign o_ready = (state == IDLE) || ((state == DONE) && i_ready);
  assign o_dv    = (state == DONE);
  assign accept  = i_dv && o_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (i_dv) state_nxt = PROCESSING;
      PROCESSING: if (idx == LAST) state_nxt = DONE;
      DONE:       if (i_ready) state_nxt = i_dv ? PROCESSING : IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // One column of MACs, then round-half-up and clamp; only committed on the last column
  always_comb begin
    y_nxt = '0;
    clamp = '0;
    for (int r = 0; r < DIM; r++) begin
      prod[r]    = PW'($signed(a_r[r][idx])) * PW'($signed(x_r[idx]));
      acc_sum[r] = acc[r] + ACCWIDTH'(prod[r]);
      rnd[r]     = RW'(acc_sum[r]) + RND_C;
      shv[r]     = rnd[r] >>> FRACBITS;
      y_nxt[r]   = shv[r][DATAWIDTH-1:0];
      if (shv[r] > SAT_MAX) begin
        y_nxt[r] = SAT_MAX[DATAWIDTH-1:0];
        clamp[r] = 1'b1;
      end else if (shv[r] < SAT_MIN) begin
        y_nxt[r] = SAT_MIN[DATAWIDTH-1:0];
        clamp[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_r        <= '0;
      x_r        <= '0;
      idx        <= '0;
      y          <= '0;
      o_overflow <= 1'b0;
      for (int r = 0; r < DIM; r++) acc[r] <= '0;
    end else if (accept) begin
      a_r <= A;
      x_r <= x;
      idx <= '0;
      for (int r = 0; r < DIM; r++) acc[r] <= '0;
    end else if (state == PROCESSING) begin
      for (int r = 0; r < DIM; r++) acc[r] <= acc_sum[r];
      idx <= idx + IDXW'(1);
      if (idx == LAST) begin
        y          <= y_nxt;
        o_overflow <= |clamp;
        idx        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mat_vec_mul_fx.sv
// Scoreboard bench for mat_vec_mul_fx: directed spec vectors plus randomized traffic
// with random downstream backpressure, checked against an arithmetic reference model.
module tb_mat_vec_mul_fx;

  localparam int DW  = 32;
  localparam int FB  = 16;
  localparam int DIM = 4;

  typedef logic [DIM-1:0][DIM-1:0][DW-1:0] mat_t;
  typedef logic [DIM-1:0][DW-1:0]          vec_t;
  typedef struct packed {
    vec_t y;
    logic ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  mat_t A;
  vec_t x, y;
  logic i_dv, o_ready, o_dv, i_ready, o_overflow;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t exp_q[$];
  int   acc_q[$];
  logic prev_dv  = 1'b0;
  logic rdy_hold = 1'b0;
  logic rdy_rand = 1'b0;

  mat_vec_mul_fx #(.DATAWIDTH(DW), .FRACBITS(FB), .DIM(DIM)) dut (
    .clk(clk), .rstn(rstn), .A(A), .x(x), .i_dv(i_dv), .o_ready(o_ready),
    .y(y), .o_dv(o_dv), .i_ready(i_ready), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // y = A*x computed exactly, then round half up and clamp to the 32-bit range
  function automatic exp_t model(input mat_t a, input vec_t v);
    exp_t e;
    logic signed [127:0] s, ea, ev;
    e = '0;
    for (int r = 0; r < DIM; r++) begin
      s = '0;
      for (int c = 0; c < DIM; c++) begin
        ea = 128'($signed(a[r][c]));
        ev = 128'($signed(v[c]));
        s  = s + ea * ev;
      end
      s = (s + (128'sd1 <<< (FB-1))) >>> FB;
      if (s > 128'sd2147483647) begin
        e.y[r] = 32'h7FFFFFFF;
        e.ovf  = 1'b1;
      end else if (s < -128'sd2147483648) begin
        e.y[r] = 32'h80000000;
        e.ovf  = 1'b1;
      end else begin
        e.y[r] = s[31:0];
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_elem();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return $urandom_range(0, 32'h80000) - 32'h40000;
  endfunction

  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      i_ready = rdy_hold ? 1'b0 : (rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Monitor: latency from accept to o_dv rise, and y/o_overflow against the scoreboard
  always @(negedge clk) begin
    if (!rstn) begin
      prev_dv = 1'b0;
    end else begin
      if (i_dv && o_ready) acc_q.push_back(cyc + 1);
      if (o_dv && !prev_dv) begin
        if (acc_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL latency: o_dv rose with no accept recorded at %0t", $time);
        end else begin
          checkOutput("latency", cyc - acc_q.pop_front(), DIM);
        end
      end
      if (o_dv) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_dv: o_dv=1 with empty scoreboard at %0t", $time);
        end else begin
          checkOutput("y", y, exp_q[0].y);
          checkOutput("overflow", o_overflow, exp_q[0].ovf);
          if (i_ready) void'(exp_q.pop_front());
        end
      end
      prev_dv = o_dv;
    end
  end

  // Called at a posedge; returns at the posedge on which the input is accepted
  task automatic applyStimulus(input mat_t a, input vec_t v, input exp_t e, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    #1;
    A = a; x = v; i_dv = 1'b1;
    exp_q.push_back(e);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      waits++;
      if (o_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("[TB] FAIL accept_timeout: o_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk);
  endtask

  task automatic dropValid();
    #1;
    i_dv = 1'b0;
    @(posedge clk);
  endtask

  task automatic waitDrain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("[TB] FAIL drain_timeout: %0d results outstanding expected 0", exp_q.size());
    end
    @(posedge clk);
  endtask

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    mat_t a;
    vec_t v;
    exp_t e;
    int   w;

    rstn = 1'b0; i_dv = 1'b0; A = '0; x = '0;
    #3;
    checkOutput("rst_y", y, 0);
    checkOutput("rst_dv", o_dv, 0);
    checkOutput("rst_ovf", o_overflow, 0);
    checkOutput("rst_ready", o_ready, 1);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);

    // Identity matrix
    a = '0;
    for (int i = 0; i < DIM; i++) a[i][i] = 32'h00010000;
    v[0] = 32'h00010000; v[1] = 32'h00020000; v[2] = 32'hFFFD0000; v[3] = 32'h00008000;
    e.y[0] = 32'h00010000; e.y[1] = 32'h00020000; e.y[2] = 32'hFFFD0000; e.y[3] = 32'h00008000;
    e.ovf = 1'b0;
    applyStimulus(a, v, e, w); dropValid(); waitDrain();

    // Counting matrix times all-ones
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) a[r][c] = 32'((r*4 + c + 1) << 16);
    for (int c = 0; c < DIM; c++) v[c] = 32'h00010000;
    e.y[0] = 32'h000A0000; e.y[1] = 32'h001A0000; e.y[2] = 32'h002A0000; e.y[3] = 32'h003A0000;
    e.ovf = 1'b0;
    applyStimulus(a, v, e, w); dropValid(); waitDrain();

    // Positive and negative saturation
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) a[r][c] = 32'h7FFF0000;
    for (int c = 0; c < DIM; c++) v[c] = 32'h7FFF0000;
    for (int r = 0; r < DIM; r++) e.y[r] = 32'h7FFFFFFF;
    e.ovf = 1'b1;
    applyStimulus(a, v, e, w); dropValid(); waitDrain();
    for (int c = 0; c < DIM; c++) v[c] = 32'h80010000;
    for (int r = 0; r < DIM; r++) e.y[r] = 32'h80000000;
    applyStimulus(a, v, e, w); dropValid(); waitDrain();

    // Rounding at exactly one half and just below
    a = '0; v = '0; a[0][0] = 32'h00000001; v[0] = 32'h00008000;
    e.y = '0; e.y[0] = 32'h00000001; e.ovf = 1'b0;
    applyStimulus(a, v, e, w); dropValid(); waitDrain();
    v[0] = 32'h00007FFF;
    e.y = '0;
    applyStimulus(a, v, e, w); dropValid(); waitDrain();

    // Randomized traffic with random backpressure and back-to-back inputs
    rdy_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) a[r][c] = rand_elem();
      for (int c = 0; c < DIM; c++) v[c] = rand_elem();
      applyStimulus(a, v, model(a, v), w);
      if ($urandom_range(0, 2) != 0) dropValid();
    end
    dropValid();
    waitDrain();
    rdy_rand = 1'b0;

    // Hold the result for 3 cycles, then release with a new input on the same edge
    rdy_hold = 1'b1;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) a[r][c] = rand_elem();
    for (int c = 0; c < DIM; c++) v[c] = rand_elem();
    applyStimulus(a, v, model(a, v), w);
    dropValid();
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (o_dv) begin seen = 1'b1; break; end
      end
      if (!seen) begin
        checks++; errors++;
        $display("[TB] FAIL bp_wait: o_dv=0 expected 1 within 20 cycles");
      end
    end
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp_ready", o_ready, 0);
      checkOutput("bp_dv", o_dv, 1);
    end
    @(posedge clk);
    rdy_hold = 1'b0;
    for (int c = 0; c < DIM; c++) v[c] = rand_elem();
    applyStimulus(a, v, model(a, v), w);
    checkOutput("bp_same_edge_accept", w, 1);
    dropValid();
    waitDrain();

    // Reset in the middle of processing aborts the vector
    for (int c = 0; c < DIM; c++) v[c] = rand_elem();
    applyStimulus(a, v, model(a, v), w);
    dropValid();
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    checkOutput("abort_y", y, 0);
    checkOutput("abort_dv", o_dv, 0);
    checkOutput("abort_ovf", o_overflow, 0);
    checkOutput("abort_ready", o_ready, 1);
    exp_q.delete();
    acc_q.delete();
    repeat (2) begin
      @(negedge clk);
      checkOutput("abort_dv_hold", o_dv, 0);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    #1 checkOutput("post_rst_ready", o_ready, 1);
    @(posedge clk);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) a[r][c] = rand_elem();
    for (int c = 0; c < DIM; c++) v[c] = rand_elem();
    applyStimulus(a, v, model(a, v), w);
    dropValid();
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
